// File: rtl/ispm_port_arbiter_if.sv
// Signal bundle between the ISPM rw-port arbiter and its three neighbours:
// the core rw path, the external bus loader and the ISPM rw port.
interface ispm_port_arbiter_if;
    logic [11:0] core_rw_addr;
    logic        core_rw_enable;
    logic        core_rw_write;
    logic [31:0] core_rw_data_in;
    logic [31:0] core_rw_data_out;
    logic        core_rw_stall;

    logic [11:0] bus_addr;
    logic        bus_write;
    logic [31:0] bus_data_in;
    logic        bus_ready;

    logic [11:0] spm_rw_addr;
    logic        spm_rw_enable;
    logic        spm_rw_write;
    logic [31:0] spm_rw_data_in;
    logic [31:0] spm_rw_data_out;

    modport slave (
        input  core_rw_addr, core_rw_enable, core_rw_write, core_rw_data_in,
        output core_rw_data_out, core_rw_stall,
        input  bus_addr, bus_write, bus_data_in,
        output bus_ready,
        output spm_rw_addr, spm_rw_enable, spm_rw_write, spm_rw_data_in,
        input  spm_rw_data_out
    );

    modport master (
        output core_rw_addr, core_rw_enable, core_rw_write, core_rw_data_in,
        input  core_rw_data_out, core_rw_stall,
        output bus_addr, bus_write, bus_data_in,
        input  bus_ready,
        input  spm_rw_addr, spm_rw_enable, spm_rw_write, spm_rw_data_in,
        output spm_rw_data_out
    );
endinterface

// File: rtl/ispm_port_arbiter.sv
// Shares the ISPM rw port between the core and a one-entry bus write buffer;
// the buffer drains on idle core cycles or is forced out by age/address conflict.
module ispm_port_arbiter #(
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ispm_port_arbiter_if.slave   arb
);

    typedef enum logic {
        EMPTY = 1'b0,
        PEND  = 1'b1
    } state_t;

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    state_t            state_q;
    state_t            state_d;
    logic [11:0]       buf_addr;
    logic [31:0]       buf_data;
    logic [WAIT_W-1:0] wait_cnt;

    logic capture;
    logic wait_inc;

    assign arb.core_rw_data_out = arb.spm_rw_data_out;
    assign arb.bus_ready        = (state_q == EMPTY) && reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        capture            = 1'b0;
        wait_inc           = 1'b0;
        arb.core_rw_stall  = 1'b0;
        arb.spm_rw_addr    = arb.core_rw_addr;
        arb.spm_rw_enable  = arb.core_rw_enable;
        arb.spm_rw_write   = arb.core_rw_write;
        arb.spm_rw_data_in = arb.core_rw_data_in;

        unique case (state_q)
            EMPTY: begin
                // The core keeps the port this cycle; the bus write only lands in the buffer.
                if (arb.bus_write && arb.bus_ready) begin
                    capture = 1'b1;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (!arb.core_rw_enable ||
                    (wait_cnt == MAX_WAIT_C) ||
                    (arb.core_rw_addr == buf_addr)) begin
                    arb.spm_rw_addr    = buf_addr;
                    arb.spm_rw_enable  = 1'b1;
                    arb.spm_rw_write   = 1'b1;
                    arb.spm_rw_data_in = buf_data;
                    arb.core_rw_stall  = arb.core_rw_enable;
                    state_d            = EMPTY;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_addr <= '0;
            buf_data <= '0;
            wait_cnt <= '0;
        end else if (capture) begin
            buf_addr <= arb.bus_addr;
            buf_data <= arb.bus_data_in;
            wait_cnt <= '0;
        end else if (wait_inc && (wait_cnt != MAX_WAIT_C)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

endmodule

// File: tb/tb_ispm_port_arbiter.sv
// Bench for ispm_port_arbiter: directed scenarios plus random traffic, checked
// against a buffer-queue / golden-memory reference model and a behavioural SPM.
module tb_ispm_port_arbiter;

    localparam int MAX_WAIT = 8;
    localparam int WAIT_W   = 4;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        int          age;
    } pend_t;

    logic clk;
    logic reset_n;

    ispm_port_arbiter_if ifc ();

    ispm_port_arbiter #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .arb     (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ISPM rw port: registered read, one-cycle latency.
    logic [31:0] spm_mem [0:4095];
    logic [31:0] spm_q;
    assign ifc.spm_rw_data_out = spm_q;

    always @(posedge clk) begin
        if (ifc.spm_rw_enable) begin
            if (ifc.spm_rw_write) spm_mem[ifc.spm_rw_addr] <= ifc.spm_rw_data_in;
            else                  spm_q <= spm_mem[ifc.spm_rw_addr];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [0:4095];
    pend_t       pend_q[$];
    logic        rd_pend;
    logic [31:0] rd_exp;
    logic        stall_last;
    logic        last_obs_stall;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: inputs are already set; check at negedge, update model, advance.
    task automatic step();
        logic  exp_ready, exp_stall, exp_drain, accepted;
        pend_t e;
        @(negedge clk);
        if (rd_pend) chk("rdata", ifc.core_rw_data_out, rd_exp);
        rd_pend   = 1'b0;
        exp_ready = reset_n && (pend_q.size() == 0);
        exp_stall = 1'b0;
        exp_drain = 1'b0;
        if (pend_q.size() != 0) begin
            if (!ifc.core_rw_enable) begin
                exp_drain = 1'b1;
            end else if (pend_q[0].age >= MAX_WAIT || ifc.core_rw_addr == pend_q[0].addr) begin
                exp_drain = 1'b1;
                exp_stall = 1'b1;
            end
        end
        chk("bus_ready", {31'd0, ifc.bus_ready}, {31'd0, exp_ready});
        chk("stall", {31'd0, ifc.core_rw_stall}, {31'd0, exp_stall});
        last_obs_stall = ifc.core_rw_stall;
        if (exp_drain) begin
            chk("drain_en", {31'd0, ifc.spm_rw_enable}, 32'd1);
            chk("drain_we", {31'd0, ifc.spm_rw_write}, 32'd1);
            chk("drain_addr", {20'd0, ifc.spm_rw_addr}, {20'd0, pend_q[0].addr});
            chk("drain_data", ifc.spm_rw_data_in, pend_q[0].data);
            ref_mem[pend_q[0].addr] = pend_q[0].data;
            pend_q.delete();
        end else begin
            chk("pass_en", {31'd0, ifc.spm_rw_enable}, {31'd0, ifc.core_rw_enable});
            if (ifc.core_rw_enable) begin
                chk("pass_we", {31'd0, ifc.spm_rw_write}, {31'd0, ifc.core_rw_write});
                chk("pass_addr", {20'd0, ifc.spm_rw_addr}, {20'd0, ifc.core_rw_addr});
                if (ifc.core_rw_write) chk("pass_data", ifc.spm_rw_data_in, ifc.core_rw_data_in);
            end
            if (pend_q.size() != 0) begin
                e = pend_q[0];
                e.age = e.age + 1;
                pend_q[0] = e;
            end
        end
        if (ifc.core_rw_enable && !exp_stall) begin
            if (ifc.core_rw_write) begin
                ref_mem[ifc.core_rw_addr] = ifc.core_rw_data_in;
            end else begin
                rd_pend = 1'b1;
                rd_exp  = ref_mem[ifc.core_rw_addr];
            end
        end
        accepted = ifc.bus_write && exp_ready;
        if (accepted) begin
            e.addr = ifc.bus_addr;
            e.data = ifc.bus_data_in;
            e.age  = 0;
            pend_q.push_back(e);
        end
        stall_last = exp_stall;
        @(posedge clk);
        #1;
        if (accepted) ifc.bus_write = 1'b0;
    endtask

    // Issue one core access, holding it for as long as the model says it is stalled.
    task automatic run_core(input logic en, input logic we, input logic [11:0] a,
                            input logic [31:0] d, output logic first_stall);
        ifc.core_rw_enable  = en;
        ifc.core_rw_write   = we;
        ifc.core_rw_addr    = a;
        ifc.core_rw_data_in = d;
        step();
        first_stall = last_obs_stall;
        while (stall_last) step();
    endtask

    task automatic core_idle();
        ifc.core_rw_enable  = 1'b0;
        ifc.core_rw_write   = 1'b0;
        ifc.core_rw_addr    = 12'h000;
        ifc.core_rw_data_in = 32'h0;
    endtask

    task automatic bus_req(input logic [11:0] a, input logic [31:0] d);
        ifc.bus_addr    = a;
        ifc.bus_data_in = d;
        ifc.bus_write   = 1'b1;
    endtask

    // Called at posedge+1; leaves reset released at posedge+1.
    task automatic pulse_reset();
        #2;
        reset_n = 1'b0;
        core_idle();
        ifc.bus_write = 1'b0;
        #1;
        chk("rst_ready", {31'd0, ifc.bus_ready}, 32'd0);
        chk("rst_stall", {31'd0, ifc.core_rw_stall}, 32'd0);
        chk("rst_wait", {{(32-WAIT_W){1'b0}}, dut.wait_cnt}, 32'd0);
        pend_q.delete();
        rd_pend    = 1'b0;
        stall_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready_hold", {31'd0, ifc.bus_ready}, 32'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic st;
        int   stall_pos, nst;
        for (int i = 0; i < 4096; i++) begin
            spm_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        spm_q      = 32'h0;
        rd_pend    = 1'b0;
        stall_last = 1'b0;
        last_obs_stall = 1'b0;
        reset_n    = 1'b0;
        core_idle();
        ifc.bus_write   = 1'b0;
        ifc.bus_addr    = 12'h0;
        ifc.bus_data_in = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("init_ready", {31'd0, ifc.bus_ready}, 32'd0);
        chk("init_stall", {31'd0, ifc.core_rw_stall}, 32'd0);
        chk("init_wait", {{(32-WAIT_W){1'b0}}, dut.wait_cnt}, 32'd0);
        reset_n = 1'b1;

        // Idle core: write drains the next cycle, ready returns after that.
        bus_req(12'h010, 32'hDEADBEEF);
        step();
        step();
        chk("tp1_spm", spm_mem[12'h010], 32'hDEADBEEF);
        step();
        run_core(1'b1, 1'b0, 12'h010, 32'h0, st);
        core_idle();
        step();

        // Busy core, no conflict: forced drain on the 9th cycle after acceptance.
        bus_req(12'h020, 32'h12345678);
        ifc.core_rw_enable = 1'b1;
        ifc.core_rw_write  = 1'b0;
        ifc.core_rw_addr   = 12'h100;
        step();
        stall_pos = 0;
        nst       = 0;
        for (int i = 1; i <= 12; i++) begin
            if (!stall_last) ifc.core_rw_addr = 12'h100 + 12'(i);
            step();
            if (last_obs_stall) begin
                nst++;
                if (stall_pos == 0) stall_pos = i;
            end
        end
        chk("tp2_stall_pos", stall_pos, 9);
        chk("tp2_nstall", nst, 1);
        chk("tp2_spm", spm_mem[12'h020], 32'h12345678);

        // Conflicting core read gets the buffered bus data.
        bus_req(12'h030, 32'hAAAA5555);
        run_core(1'b1, 1'b0, 12'h200, 32'h0, st);
        run_core(1'b1, 1'b0, 12'h030, 32'h0, st);
        chk("tp3_stall", {31'd0, st}, 32'd1);
        core_idle();
        step();

        // Conflicting core write wins ordering.
        bus_req(12'h040, 32'h11111111);
        run_core(1'b1, 1'b0, 12'h201, 32'h0, st);
        run_core(1'b1, 1'b1, 12'h040, 32'h22222222, st);
        chk("tp4_stall", {31'd0, st}, 32'd1);
        run_core(1'b1, 1'b0, 12'h040, 32'h0, st);
        core_idle();
        step();
        chk("tp4_spm", spm_mem[12'h040], 32'h22222222);

        // Bus holds a second write while the buffer is full and the core is busy.
        bus_req(12'h060, 32'h0BADF00D);
        run_core(1'b1, 1'b0, 12'h300, 32'h0, st);
        bus_req(12'h061, 32'h13579BDF);
        for (int i = 1; i <= 12; i++) run_core(1'b1, 1'b0, 12'h300 + 12'(i), 32'h0, st);
        core_idle();
        repeat (2) step();
        chk("tp5_spm0", spm_mem[12'h060], 32'h0BADF00D);
        chk("tp5_spm1", spm_mem[12'h061], 32'h13579BDF);

        // Reset mid-PEND discards the buffered write.
        bus_req(12'h050, 32'hCAFEF00D);
        run_core(1'b1, 1'b0, 12'h400, 32'h0, st);
        run_core(1'b1, 1'b0, 12'h401, 32'h0, st);
        pulse_reset();
        step();
        repeat (2) step();
        chk("tp6_spm", spm_mem[12'h050], 32'h0);
        run_core(1'b1, 1'b0, 12'h050, 32'h0, st);
        core_idle();
        step();

        // Random traffic over a small address window to provoke conflicts.
        for (int c = 0; c < 600; c++) begin
            if (!stall_last) begin
                ifc.core_rw_enable  = ($urandom % 10) < 7;
                ifc.core_rw_write   = ($urandom % 3) == 0;
                ifc.core_rw_addr    = 12'($urandom % 16);
                ifc.core_rw_data_in = $urandom;
            end
            if (!ifc.bus_write && ($urandom % 10) < 4)
                bus_req(12'($urandom % 16), $urandom);
            step();
        end
        core_idle();
        ifc.bus_write = 1'b0;
        repeat (3) step();
        for (int a = 0; a < 16; a++) chk("rand_mem", spm_mem[a], ref_mem[a]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
